// File: rtl/temp_stats_pkg.sv
// Shared definitions for the sliding-window temperature statistics engine.
//   state_e      : engine FSM states (IDLE -> SCAN -> DIV -> DONE -> IDLE)
//   cnt_width()  : bits needed to hold a fill count of 0..depth
//   ptr_width()  : bits needed to address depth window entries
//   sum_width()  : running-sum width that cannot overflow for a full window
//   MIN_RESET_BIT: min_temp resets to this bit replicated (all-ones), so the
//                  first real sample always becomes the minimum
package temp_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MIN_RESET_BIT = 1'b1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int sum_width(input int data_w, input int depth);
    return data_w + cnt_width(depth);
  endfunction

endpackage

// File: rtl/temp_window_stats_seq_divider.sv
// Unsigned restoring divider with a fixed SUM_W-cycle latency.
//   clk, rst     : clock, asynchronous active-high reset
//   flush_i      : synchronous abort of an iteration in flight
//   start_i      : load dividend_i/divisor_i; iterations run on the next
//                  SUM_W edges
//   dividend_i   : SUM_W-bit dividend
//   divisor_i    : CNT_W-bit divisor, must be non-zero
//   done_o       : high in the cycle whose closing edge performs the final
//                  iteration; quotient_o is valid from that edge onward
//   quotient_o   : low QUO_W bits of floor(dividend / divisor)
module seq_divider #(
  parameter int SUM_W = 12,
  parameter int CNT_W = 4,
  parameter int QUO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             done_o,
  output logic [QUO_W-1:0] quotient_o
);

  localparam int ITER_W = $clog2(SUM_W + 1);

  logic [ITER_W-1:0] iter_q;
  logic [CNT_W-1:0]  rem_q, rem_d, dvs_q;
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W:0]    rem_sh;

  // quo_q starts as the dividend: its MSB is shifted into the remainder each
  // step while the new quotient bit enters at the LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[SUM_W-1]};
    rem_d  = rem_sh[CNT_W-1:0];
    quo_d  = {quo_q[SUM_W-2:0], 1'b0};
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_d = CNT_W'(rem_sh - {1'b0, dvs_q});
      quo_d = {quo_q[SUM_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (flush_i) begin
      iter_q <= '0;
    end else if (start_i) begin
      iter_q <= ITER_W'(SUM_W);
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (iter_q != '0) begin
      iter_q <= iter_q - ITER_W'(1);
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

  assign done_o     = (iter_q == ITER_W'(1));
  assign quotient_o = quo_q[QUO_W-1:0];

endmodule

// File: rtl/temp_window_stats.sv
// Sliding-window statistics over the last DEPTH temperature samples.
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : synchronous flush of window and outputs
//   in_data/in_valid/in_ready : sample input. A sample transfers on a rising
//                     edge where in_valid && in_ready; in_ready does not wait
//                     on in_valid, and an offer made while in_ready is low is
//                     dropped, not held.
//   avg/max/min_temp, sample_count : statistics over filled entries, updated
//                     together on the stats_valid pulse
//   stats_valid     : one-cycle strobe marking an output update
//   dbg_state_o     : current FSM state
//   dbg_wr_ptr_o    : window write pointer (zero-extended)
module temp_window_stats
  import temp_stats_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10,
  parameter int ROUND  = 0,
  parameter int CNT_W  = cnt_width(DEPTH),
  parameter int SUM_W  = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] avg_temp,
  output logic [DATA_W-1:0] max_temp,
  output logic [DATA_W-1:0] min_temp,
  output logic [CNT_W-1:0]  sample_count,
  output logic              stats_valid,
  output state_e            dbg_state_o,
  output logic [CNT_W-1:0]  dbg_wr_ptr_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [DATA_W-1:0] MIN_RESET = {DATA_W{MIN_RESET_BIT}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q, scan_idx_q, sample_count_q;
  logic [SUM_W-1:0]  sum_q, dividend;
  logic [DATA_W-1:0] run_max_q, run_min_q, avg_q, max_q, min_q, scan_val, oldest, quotient;
  logic              stats_valid_q, accept, scan_last, div_start, div_done;

  assign accept    = in_valid && in_ready;
  assign oldest    = mem[wr_ptr_q];
  assign scan_val  = mem[scan_idx_q[PTR_W-1:0]];
  assign scan_last = (scan_idx_q == count_q - CNT_W'(1));
  assign div_start = (state_q == ST_SCAN) && scan_last && !clear;
  assign dividend  = sum_q + ((ROUND != 0) ? SUM_W'(count_q >> 1) : {SUM_W{1'b0}});

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !clear;
        if (accept) state_d = ST_SCAN;
      end
      ST_SCAN: if (scan_last) state_d = ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Window storage is never reset: only entries below count_q are read.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;        count_q <= '0;        sum_q <= '0;
      scan_idx_q <= '0;      run_max_q <= '0;      run_min_q <= MIN_RESET;
      avg_q <= '0;           max_q <= '0;          min_q <= MIN_RESET;
      sample_count_q <= '0;  stats_valid_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q <= '0;        count_q <= '0;        sum_q <= '0;
      scan_idx_q <= '0;      run_max_q <= '0;      run_min_q <= MIN_RESET;
      avg_q <= '0;           max_q <= '0;          min_q <= MIN_RESET;
      sample_count_q <= '0;  stats_valid_q <= 1'b0;
    end else begin
      stats_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            // A full window drops the entry being overwritten from the sum.
            if (count_q == CNT_W'(DEPTH)) begin
              sum_q <= sum_q - SUM_W'(oldest) + SUM_W'(in_data);
            end else begin
              sum_q   <= sum_q + SUM_W'(in_data);
              count_q <= count_q + CNT_W'(1);
            end
            scan_idx_q <= '0;
            run_max_q  <= '0;
            run_min_q  <= MIN_RESET;
          end
        end
        ST_SCAN: begin
          scan_idx_q <= scan_idx_q + CNT_W'(1);
          if (scan_val > run_max_q) run_max_q <= scan_val;
          if (scan_val < run_min_q) run_min_q <= scan_val;
        end
        ST_DONE: begin
          avg_q          <= quotient;
          max_q          <= run_max_q;
          min_q          <= run_min_q;
          sample_count_q <= count_q;
          stats_valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The quotient never exceeds the largest sample, so its low DATA_W bits
  // are the whole result.
  seq_divider #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W),
    .QUO_W (DATA_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (clear),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (count_q),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  assign avg_temp     = avg_q;
  assign max_temp     = max_q;
  assign min_temp     = min_q;
  assign sample_count = sample_count_q;
  assign stats_valid  = stats_valid_q;
  assign dbg_state_o  = state_q;
  assign dbg_wr_ptr_o = CNT_W'(wr_ptr_q);

endmodule

// File: tb/tb_temp_window_stats.sv
module tb_temp_window_stats;
  import temp_stats_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 10;
  localparam int CNT_W  = 4;
  localparam int SUM_W  = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, clear, in_valid;
  logic [DATA_W-1:0] in_data;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two instances share stimulus: truncating and rounding average.
  logic              rdy0, rdy1, sv0, sv1;
  logic [DATA_W-1:0] avg0, max0, min0, avg1, max1, min1;
  logic [CNT_W-1:0]  cnt0, cnt1, wp0, wp1;
  state_e            st0, st1;

  temp_window_stats #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROUND(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .avg_temp(avg0), .max_temp(max0), .min_temp(min0),
    .sample_count(cnt0), .stats_valid(sv0), .dbg_state_o(st0), .dbg_wr_ptr_o(wp0));

  temp_window_stats #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROUND(1)) u_dut_r (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .avg_temp(avg1), .max_temp(max1), .min_temp(min1),
    .sample_count(cnt1), .stats_valid(sv1), .dbg_state_o(st1), .dbg_wr_ptr_o(wp1));

  // ---------------- scoreboard ----------------
  typedef struct {
    int avg_t;
    int avg_r;
    int mx;
    int mn;
    int cnt;
    int at;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t e0, e1;
  int   win[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: window as a queue of the last DEPTH samples.
  task automatic model_push(input int d, input int acc_cyc);
    exp_t e;
    int sum, n;
    win.push_back(d);
    if (win.size() > DEPTH) void'(win.pop_front());
    n = win.size();
    sum = 0; e.mx = 0; e.mn = 255;
    foreach (win[i]) begin
      sum += win[i];
      if (win[i] > e.mx) e.mx = win[i];
      if (win[i] < e.mn) e.mn = win[i];
    end
    e.avg_t = sum / n;
    e.avg_r = (sum + n / 2) / n;
    e.cnt   = n;
    e.at    = acc_cyc + n + SUM_W + 1;
    exp_q0.push_back(e);
    exp_q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst === 1'b0 && sv0 === 1'b1) begin
      if (exp_q0.size() == 0) check("dut0_unexpected_valid", 1, 0);
      else begin
        e0 = exp_q0.pop_front();
        check("dut0_avg", int'(avg0), e0.avg_t);
        check("dut0_max", int'(max0), e0.mx);
        check("dut0_min", int'(min0), e0.mn);
        check("dut0_count", int'(cnt0), e0.cnt);
        check("dut0_latency", cyc, e0.at);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst === 1'b0 && sv1 === 1'b1) begin
      if (exp_q1.size() == 0) check("dut1_unexpected_valid", 1, 0);
      else begin
        e1 = exp_q1.pop_front();
        check("dut1_avg_round", int'(avg1), e1.avg_r);
        check("dut1_max", int'(max1), e1.mx);
        check("dut1_min", int'(min1), e1.mn);
        check("dut1_count", int'(cnt1), e1.cnt);
        check("dut1_latency", cyc, e1.at);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int w = 0;
    while (rdy0 !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 100) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Offer one sample; optionally keep in_valid high with junk data while the
  // engine is busy (those offers must be ignored). Returns after stats_valid.
  task automatic send(input int d, input bit hold);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    wait_ready();
    @(posedge clk);
    #1;
    model_push(d, cyc);
    if (hold) in_data = DATA_W'($urandom_range(0, 255));
    else      in_valid = 1'b0;
    while (1) begin
      @(negedge clk);
      if (sv0 === 1'b1) break;
      w++;
      if (w > 200) begin
        check("stats_valid_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Offer a sample whose computation is about to be aborted.
  task automatic send_nowait(input int d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    wait_ready();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_avg0"}, int'(avg0), 0);
    check({tag, "_max0"}, int'(max0), 0);
    check({tag, "_min0"}, int'(min0), 255);
    check({tag, "_cnt0"}, int'(cnt0), 0);
    check({tag, "_sv0"}, int'(sv0), 0);
    check({tag, "_avg1"}, int'(avg1), 0);
    check({tag, "_min1"}, int'(min1), 255);
    check({tag, "_cnt1"}, int'(cnt1), 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("clear_in_ready_low", int'(rdy0), 0);
    @(negedge clk);
    clear = 1'b0;
    win.delete();
    check_reset("clear");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;

    // 1: asynchronous reset mid-cycle
    #23 rst = 1'b1;
    #1;
    check_reset("rst_async");
    check("rst_in_ready", int'(rdy0), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // 2: single sample with in_valid held during busy
    send(25, 1'b1);
    check("single_avg", int'(avg0), 25);
    check("single_count", int'(cnt0), 1);
    do_clear();

    // 3: fill the window
    for (int i = 1; i <= 10; i++) send(i * 10, 1'b0);
    check("fill_avg", int'(avg0), 55);
    check("fill_min", int'(min0), 10);
    check("fill_max", int'(max0), 100);
    check("fill_count", int'(cnt0), 10);
    check("fill_wr_ptr", int'(wp0), 0);

    // 4: first overwrite, then wrap with random samples
    send(200, 1'b0);
    check("ovw_avg", int'(avg0), 74);
    check("ovw_min", int'(min0), 20);
    check("ovw_max", int'(max0), 200);
    check("ovw_count", int'(cnt0), 10);
    check("ovw_wr_ptr", int'(wp0), 1);
    for (int i = 0; i < 25; i++) send($urandom_range(0, 255), 1'($urandom_range(0, 1)));

    // 5: rounding and all-ones window
    do_clear();
    send(1, 1'b0);
    send(2, 1'b0);
    check("trunc_avg", int'(avg0), 1);
    check("round_avg", int'(avg1), 2);
    do_clear();
    for (int i = 0; i < 10; i++) send(255, 1'b0);
    check("max_avg_trunc", int'(avg0), 255);
    check("max_avg_round", int'(avg1), 255);

    // random stretch across fill and wrap
    do_clear();
    for (int i = 0; i < 30; i++) send($urandom_range(0, 255), 1'($urandom_range(0, 1)));

    // 6: clear during SCAN (with a colliding sample), then rst during DIV
    send_nowait($urandom_range(0, 255));
    @(negedge clk);
    check("scan_state", int'(st0), int'(ST_SCAN));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd77;
    #1;
    check("clear_valid_in_ready", int'(rdy0), 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    win.delete();
    check_reset("clear_scan");

    send_nowait(99);
    repeat (4) @(posedge clk);
    #2;
    check("div_state", int'(st0), int'(ST_DIV));
    rst = 1'b1;
    #1;
    check_reset("rst_div");
    check("rst_div_state", int'(st0), int'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    win.delete();
    repeat (40) @(negedge clk);

    send(7, 1'b0);
    check("after_abort_avg", int'(avg0), 7);
    check("after_abort_min", int'(min0), 7);
    check("after_abort_max", int'(max0), 7);
    check("after_abort_count", int'(cnt0), 1);

    // ---------------- report ----------------
    repeat (5) @(negedge clk);
    check("dut0_pending", exp_q0.size(), 0);
    check("dut1_pending", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/temp_window_stats.md
Name: temp_window_stats

Overview:
- Parametrised sliding-window statistics engine for the temperature path.
- Accepts one DATA_W sample per handshake into a DEPTH-entry circular window.
- Produces average, maximum and minimum over the filled entries only, plus a one-cycle stats_valid strobe.
- Replaces the fixed 10×8-bit single-cycle loop: a running sum, a sequential min/max scan and a sequential divider allow large DEPTH/DATA_W at full clock rate.

Parameters:
- DATA_W, 8: sample and result width (unsigned).
- DEPTH, 10: window length in samples; ≥2, need not be a power of two.
- ROUND, 0: 0 = truncating average; 1 = round-half-up average.
- CNT_W, $clog2(DEPTH+1): width of sample_count.
- SUM_W, DATA_W+CNT_W: running-sum width; cannot overflow.

Ports:
- clk  in  1  system clock (CLK100MHZ domain).
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous window flush; highest priority after rst.
- in_data  in  DATA_W  new temperature sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept; high only in IDLE with clear low.
- avg_temp  out  DATA_W  window average.
- max_temp  out  DATA_W  window maximum.
- min_temp  out  DATA_W  window minimum.
- sample_count  out  CNT_W  filled entries, saturating at DEPTH.
- stats_valid  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset and clear values:
  - avg_temp=0, max_temp=0, min_temp=all-ones, sample_count=0, stats_valid=0.
  - Write pointer=0, running sum=0, state=IDLE.
  - Window storage needs no reset; only entries below count are ever read.
- Accept at edge E0 when in_valid && in_ready:
  - Write in_data at wr_ptr. wr_ptr wraps from DEPTH-1 to 0.
  - If count==DEPTH: sum <= sum - oldest + in_data (oldest = entry at wr_ptr before the write). Otherwise sum <= sum + in_data and count++.
  - Go to SCAN.
- FSM IDLE → SCAN → DIV → DONE → IDLE:
  - SCAN: one entry per cycle, indices 0..count-1, so k cycles for k filled entries. Running max is seeded with 0, running min with all-ones; compares are unsigned.
  - DIV: seq_divider computes (sum + (ROUND ? count>>1 : 0)) / count, floor. Fixed SUM_W cycles. Divisor is never 0 in DIV.
  - DONE: at edge E(k+SUM_W+1), register avg/max/min/sample_count and assert stats_valid for exactly that one cycle. Return to IDLE.
  - in_ready is high again in the stats_valid cycle.
- Latency: acceptance edge to stats_valid = k+SUM_W+1 edges, where k is the post-insert count.
- Busy: in_ready=0 in SCAN/DIV/DONE. in_valid while busy is ignored, not queued.
- Outputs hold their previous values between updates and are never partially updated.
- clear:
  - In any state it aborts the computation and restores all reset values next edge; no stats_valid from the aborted computation.
  - clear with in_valid in the same cycle: clear wins and the sample is dropped (in_ready is low).
- rst mid-operation: immediate asynchronous return to the reset values.
- avg width: the quotient is ≤ 2^DATA_W-1 by construction (including rounding); truncate to DATA_W.

Decomposition:
- temp_stats_pkg: state enum (IDLE, SCAN, DIV, DONE), clog2-based width helper functions, reset constants (MIN_RESET = all-ones).
- Sub-module seq_divider:
  - Unsigned restoring divider, SUM_W-bit dividend, CNT_W-bit divisor.
  - start/done handshake, fixed SUM_W-cycle latency.
  - Reused elsewhere in the display-averaging path.

Test Plan (DEPTH=10, DATA_W=8, SUM_W=12):
1. Assert rst asynchronously mid-cycle -> outputs immediately 0/0/255, sample_count=0, in_ready=1, stats_valid=0.
2. One sample 25 -> stats_valid exactly 14 edges after acceptance; avg=25, min=25, max=25, count=1. in_valid held high during busy is not accepted.
3. Samples 10,20,...,100 -> after the 10th: avg=55, min=10, max=100, count=10, wr_ptr=0.
4. Continue with 200 -> window 20..100 plus 200: sum=740, avg=74, min=20, max=200, count stays 10. Continue through 25 further samples to check wrap and sum integrity against a reference model.
5. Samples 1,2 with ROUND=0 -> avg=1; rerun with ROUND=1 -> avg=2. Also 255×10 -> avg=255, no overflow.
6. clear during SCAN, then rst during DIV -> no stats_valid, outputs return to reset values; next sample 7 -> avg=7, min=7, max=7, count=1.
